// File: rtl/sa_pkg.sv
// Shared constants and drain FSM state type for the systolic-array result path.
package sa_pkg;
  localparam int SA_N  = 4;
  localparam int SA_DW = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2
  } state_t;
endpackage

// File: rtl/result_buf.sv
// Snapshot buffer for N*N result words: single-cycle parallel write, indexed read.
module result_buf
  import sa_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int DW = SA_DW
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [N*N*DW-1:0]        wdata,
  input  logic [$clog2(N*N)-1:0]   ridx,
  output logic [DW-1:0]            rdata
);
  logic [N*N-1:0][DW-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d = wdata;
  end

  // Contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign rdata = mem_q[ridx];
endmodule

// File: rtl/result_drain.sv
// Captures the PE result array on a done rising edge and streams it out word by word
// over a valid/ready port. Define RESULT_DRAIN_SUM_EN to add the running-sum outputs.
module result_drain
  import sa_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int DW = SA_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done,
  input  logic [N*N*DW-1:0]        res_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(N*N)-1:0]   out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overrun
`ifdef RESULT_DRAIN_SUM_EN
  ,
  output logic [DW-1:0]            sum,
  output logic                     sum_valid
`endif
);
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            done_q;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            rise, xfer, buf_we;
  logic [IW-1:0]   ridx;
  logic [DW-1:0]   rdata;

  assign rise = done & ~done_q;
  assign xfer = out_valid_q & out_ready;

  // Read port looks one word ahead so out_data can be registered.
  assign ridx = (state_q == STREAM && idx_q != LAST) ? idx_q + IW'(1) : '0;

  result_buf #(.N(N), .DW(DW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .wdata (res_in),
    .ridx  (ridx),
    .rdata (rdata)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;
    buf_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          buf_we  = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d     = STREAM;
        idx_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = rdata;
        out_last_d  = (LAST == '0);
      end
      STREAM: begin
        if (xfer) begin
          if (idx_q == LAST) begin
            state_d     = IDLE;
            idx_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            idx_d      = idx_q + IW'(1);
            out_data_d = rdata;
            out_last_d = (idx_q + IW'(1) == LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rise && state_q != IDLE) overrun_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      done_q      <= done;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

`ifdef RESULT_DRAIN_SUM_EN
  logic [DW-1:0] sum_q, sum_d;
  logic          sum_valid_q, sum_valid_d;

  always_comb begin
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    if (state_q == CAPTURE) sum_d = '0;
    if (xfer) begin
      sum_d       = sum_q + out_data_q;
      sum_valid_d = (idx_q == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
`endif
endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter N, default 4, array dimension (N x N results).
REQ-002 SHALL have parameter DW, default 64, result word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port done  input  1  array completion flag, level, may stay high.
REQ-006 SHALL have port res_in  input  N*N*DW  flattened PE results; PE k at bits [k*DW +: DW], k = row*N+col.
REQ-007 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-009 SHALL have port out_data  output  DW  current result word.
REQ-010 SHALL have port out_idx  output  $clog2(N*N)  index k of out_data.
REQ-011 SHALL have port out_last  output  1  high with out_valid when out_idx = N*N-1.
REQ-012 SHALL have port busy  output  1  high in CAPTURE or STREAM.
REQ-013 SHALL have port overrun  output  1  sticky: done rising edge seen while busy.

Function
REQ-014 SHALL detect a done rising edge as done & ~done_q, where done_q is done registered one cycle.
REQ-015 SHALL implement states IDLE, CAPTURE, STREAM.
REQ-016 SHALL, in IDLE on a done rising edge, register all of res_in into an N*N x DW buffer, then enter CAPTURE.
REQ-017 SHALL spend exactly one cycle in CAPTURE, then enter STREAM with index 0, so out_valid rises 2 cycles after the edge.
REQ-018 SHALL, in STREAM, assert out_valid with out_data = buffer[idx] and out_idx = idx.
REQ-019 SHALL complete a transfer only on a cycle with out_valid & out_ready high.
REQ-020 SHALL hold out_data, out_idx and out_last stable while out_valid & ~out_ready.
REQ-021 SHALL advance idx by 1 per transfer, giving back-to-back words at one per cycle while out_ready is high.
REQ-022 SHALL, on the transfer with idx = N*N-1, deassert out_valid next cycle, return to IDLE and clear idx to 0 (no wrap into a second pass).
REQ-023 SHALL ignore a done rising edge while busy, leave the buffer unchanged, and set overrun.
REQ-024 SHALL accept a new done rising edge in the first IDLE cycle after a drain.
REQ-025 SHALL never modify buffer contents in CAPTURE or STREAM; res_in changes there have no effect.
REQ-026 SHALL pass data unmodified; no arithmetic on result words.

Reset
REQ-027 SHALL, with rst high at a clock edge, set state IDLE, idx 0, done_q 0, out_valid 0, out_last 0, busy 0, overrun 0 and out_data 0; buffer contents are don't-care.
REQ-028 SHALL abort a drain when rst is asserted mid-STREAM; out_valid is low in the cycle after the reset edge.
REQ-029 SHALL treat done already high on the first cycle after reset release as a rising edge.

Configuration
REQ-030 SHALL, with macro RESULT_DRAIN_SUM_EN defined, add outputs sum (DW, modulo-2^DW running sum of transferred words) and sum_valid (1-cycle pulse after the last transfer).
REQ-031 SHALL clear sum to 0 on reset and on entry to CAPTURE.
REQ-032 SHALL, without RESULT_DRAIN_SUM_EN, omit sum, sum_valid and all related logic.

Structure
REQ-033 SHALL place the state enum and default N and DW constants in the shared package sa_pkg.
REQ-034 SHALL implement the buffer as the sub-module result_buf: N*N x DW, parallel write and indexed read.

Verification
REQ-035 Bench SHALL cover: res_in[k] = 64'h100+k, done pulse, out_ready held 1 -> 16 words 0x100..0x10F on consecutive cycles starting 2 cycles after the edge, out_last only on idx 15.
REQ-036 Bench SHALL cover: out_ready toggled 1,0,0,1 repeatedly -> no word lost or duplicated, and outputs stable during stalls.
REQ-037 Bench SHALL cover: done held high for 40 cycles -> exactly one drain and overrun stays 0.
REQ-038 Bench SHALL cover: second done edge at idx 5, with res_in changed -> original values still streamed and overrun = 1 until reset.
REQ-039 Bench SHALL cover: rst at idx 7 -> out_valid 0 the next cycle, then a new done edge restarts from idx 0.
REQ-040 Bench SHALL cover, with RESULT_DRAIN_SUM_EN: all res_in = 64'hFFFF_FFFF_FFFF_FFFF -> sum = 64'hFFFF_FFFF_FFFF_FFF0 and sum_valid pulses once.
